// File: rtl/arb_rr_pkt_pkg.sv
// Shared types and constants for the packet-locking output-port arbiter.
package noc_arb_pkg;

   // Default number of requesting input ports on one router output
   localparam int NPORT_DEF = 5;

   // Arbiter FSM: IDLE waits for any request, LOCK holds a grant for a packet
   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   // Traffic class encoding as presented on grt_mc
   localparam logic CLS_UC = 1'b0;
   localparam logic CLS_MC = 1'b1;

   // Generic enable/disable levels
   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/arb_rr_pkt_rr_pick.sv
// rr_pick: combinational round-robin find-first-set.
// Searches i_req starting at (i_ptr+1) mod NPORT upward with wrap-around.
module rr_pick
   import noc_arb_pkg::*;
#(
   parameter int NPORT = 5,
   parameter int IDW   = $clog2(NPORT)
) (
   input  logic [NPORT-1:0] i_req,
   input  logic [IDW-1:0]   i_ptr,
   output logic             o_hit,
   output logic [IDW-1:0]   o_idx
);

   // Walk offsets from farthest to nearest so the nearest set bit is written last and wins
   always_comb begin
      logic [IDW-1:0] w_cand;
      o_hit  = DISABLE;
      o_idx  = '0;
      w_cand = '0;
      for (int i = NPORT; i >= 1; i--) begin
         w_cand = IDW'((int'(i_ptr) + i) % NPORT);
         if (i_req[w_cand]) begin
            o_hit = ENABLE;
            o_idx = w_cand;
         end
      end
   end

endmodule

// File: rtl/arb_rr_pkt.sv
// arb_rr_pkt: packet-locking round-robin arbiter for one router output port.
// Multicast beats unicast; each class has its own round-robin pointer.
// A grant is registered and held until the owner's tail flit or request drop.
// Optional macro ARB_STARVE_EN bounds consecutive multicast wins while
// unicast waits (STARVE_MAX); without it multicast priority is strict.
module arb_rr_pkt
   import noc_arb_pkg::*;
#(
   parameter int NPORT      = NPORT_DEF,
   parameter int IDW        = $clog2(NPORT),
   parameter int STARVE_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NPORT-1:0] u_req,
   input  logic [NPORT-1:0] m_req,
   input  logic [NPORT-1:0] multab_ct,
   input  logic [NPORT-1:0] tail,
   output logic [NPORT-1:0] grt,
   output logic             grt_mc,
   output logic [IDW-1:0]   grt_id,
   output logic             busy
);

   localparam logic [NPORT-1:0] ONE_HOT0 = NPORT'(1);

   arb_state_t       r_state, w_state_next;
   logic [NPORT-1:0] r_grt, w_grt_next;
   logic             r_grt_mc, w_grt_mc_next;
   logic [IDW-1:0]   r_grt_id, w_grt_id_next;
   logic             r_busy, w_busy_next;
   logic [IDW-1:0]   r_ptr_m, w_ptr_m_next;
   logic [IDW-1:0]   r_ptr_u, w_ptr_u_next;

   logic [NPORT-1:0] w_m_elig, w_u_elig;
   logic             w_m_hit, w_u_hit;
   logic [IDW-1:0]   w_m_idx, w_u_idx;
   logic             w_own_tail, w_own_req, w_arb;
   logic             w_force_uc, w_sel_mc, w_sel_uc;

   assign w_m_elig = m_req & ~multab_ct;
   assign w_u_elig = u_req;

   rr_pick #(.NPORT(NPORT), .IDW(IDW)) u_pick_m (
      .i_req (w_m_elig),
      .i_ptr (r_ptr_m),
      .o_hit (w_m_hit),
      .o_idx (w_m_idx)
   );

   rr_pick #(.NPORT(NPORT), .IDW(IDW)) u_pick_u (
      .i_req (w_u_elig),
      .i_ptr (r_ptr_u),
      .o_hit (w_u_hit),
      .o_idx (w_u_idx)
   );

   // A locked packet ends on the owner's tail flit, or aborts when its class request drops
   assign w_own_tail = tail[r_grt_id];
   assign w_own_req  = (r_grt_mc == CLS_MC) ? m_req[r_grt_id] : u_req[r_grt_id];
   assign w_arb      = (r_state == IDLE) || ((r_state == LOCK) && (w_own_tail || !w_own_req));

   assign w_sel_mc = w_m_hit && !w_force_uc;
   assign w_sel_uc = w_u_hit && !w_sel_mc;

`ifdef ARB_STARVE_EN
   localparam int SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [SCW-1:0] r_starve_cnt;

   assign w_force_uc = (r_starve_cnt == SCW'(STARVE_MAX)) && (|w_u_elig);

   // Count multicast wins taken while unicast is waiting; any unicast win or uncontested multicast win clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (w_arb) begin
         if (w_sel_mc) begin
            r_starve_cnt <= (|w_u_elig) ? (r_starve_cnt + SCW'(1)) : '0;
         end else if (w_sel_uc) begin
            r_starve_cnt <= '0;
         end
      end
   end
`else
   assign w_force_uc = DISABLE;
`endif

   // Next grant, class, pointers and FSM state; everything holds unless arbitration is open
   always_comb begin
      w_state_next  = r_state;
      w_grt_next    = r_grt;
      w_grt_mc_next = r_grt_mc;
      w_grt_id_next = r_grt_id;
      w_busy_next   = r_busy;
      w_ptr_m_next  = r_ptr_m;
      w_ptr_u_next  = r_ptr_u;
      if (w_arb) begin
         if (w_sel_mc) begin
            w_state_next  = LOCK;
            w_grt_next    = ONE_HOT0 << w_m_idx;
            w_grt_mc_next = CLS_MC;
            w_grt_id_next = w_m_idx;
            w_busy_next   = ENABLE;
            w_ptr_m_next  = w_m_idx;
         end else if (w_sel_uc) begin
            w_state_next  = LOCK;
            w_grt_next    = ONE_HOT0 << w_u_idx;
            w_grt_mc_next = CLS_UC;
            w_grt_id_next = w_u_idx;
            w_busy_next   = ENABLE;
            w_ptr_u_next  = w_u_idx;
         end else begin
            // Nothing eligible: drop the grant but keep grt_id pointing at the last owner
            w_state_next  = IDLE;
            w_grt_next    = '0;
            w_grt_mc_next = CLS_UC;
            w_busy_next   = DISABLE;
         end
      end
   end

   // State and output registers; pointers reset to NPORT-1 so port 0 has first priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_grt    <= '0;
         r_grt_mc <= CLS_UC;
         r_grt_id <= '0;
         r_busy   <= DISABLE;
         r_ptr_m  <= IDW'(NPORT - 1);
         r_ptr_u  <= IDW'(NPORT - 1);
      end else begin
         r_state  <= w_state_next;
         r_grt    <= w_grt_next;
         r_grt_mc <= w_grt_mc_next;
         r_grt_id <= w_grt_id_next;
         r_busy   <= w_busy_next;
         r_ptr_m  <= w_ptr_m_next;
         r_ptr_u  <= w_ptr_u_next;
      end
   end

   assign grt    = r_grt;
   assign grt_mc = r_grt_mc;
   assign grt_id = r_grt_id;
   assign busy   = r_busy;

endmodule
